// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the radix-2 FFT datapath stages.
// Used by the input reordering stage and the later butterfly stages.
package fft_pkg;

    localparam int MSB_DEF   = 8;
    localparam int LOG2N_DEF = 3;

    // Selects one of the two ping-pong frame banks.
    typedef logic bank_idx_t;

    // Reverses the low log2n bits of idx. Bits at or above log2n come back zero.
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int log2n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < log2n) begin
                r[i] = idx[log2n-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_bank.sv
// One N x MSB frame of sample storage: a registered write port and a
// combinational read port. Contents are not reset.
module frame_bank #(
    parameter int MSB   = 8,
    parameter int LOG2N = 3
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [LOG2N-1:0] i_waddr,
    input  logic [MSB-1:0]   i_wdata,
    input  logic [LOG2N-1:0] i_raddr,
    output logic [MSB-1:0]   o_rdata
);
    localparam int N = 1 << LOG2N;

    logic [MSB-1:0] r_mem [N];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bitrev_loader.sv
// Ping-pong frame buffer that accepts natural-order samples and replays each
// complete frame in bit-reversed order, with the lane select for the demux.
module bitrev_loader
    import fft_pkg::*;
#(
    parameter int MSB   = MSB_DEF,
    parameter int LOG2N = LOG2N_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [MSB-1:0] in_data,
    output logic           in_ready,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [MSB-1:0] out_data,
    output logic           out_sel,
    output logic           out_first,
    output logic           out_last
);
    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    bank_idx_t        r_wb;
    bank_idx_t        r_rb;
    logic [LOG2N-1:0] r_wp;
    logic [LOG2N-1:0] r_rp;
    logic [1:0]       r_full;
    logic [1:0]       w_full_nxt;
    logic             w_in_acc;
    logic             w_out_acc;
    logic [LOG2N-1:0] w_raddr;
    logic [MSB-1:0]   w_rdata [2];

    assign in_ready  = !r_full[r_wb];
    assign out_valid = r_full[r_rb];
    assign w_in_acc  = in_valid && in_ready;
    assign w_out_acc = out_valid && out_ready;
    assign w_raddr   = LOG2N'(bitrev(32'(r_rp), LOG2N));

    for (genvar g = 0; g < 2; g++) begin : g_bank
        frame_bank #(
            .MSB   (MSB),
            .LOG2N (LOG2N)
        ) u_bank (
            .i_clk   (clk),
            .i_we    (w_in_acc && (r_wb == bank_idx_t'(g))),
            .i_waddr (r_wp),
            .i_wdata (in_data),
            .i_raddr (w_raddr),
            .o_rdata (w_rdata[g])
        );
    end

    // Write and read sides always own different banks, so set and clear never collide.
    always_comb begin
        w_full_nxt = r_full;
        if (w_in_acc && (r_wp == LAST_IDX)) begin
            w_full_nxt[r_wb] = 1'b1;
        end
        if (w_out_acc && (r_rp == LAST_IDX)) begin
            w_full_nxt[r_rb] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb   <= 1'b0;
            r_rb   <= 1'b0;
            r_wp   <= '0;
            r_rp   <= '0;
            r_full <= 2'b00;
        end else begin
            r_full <= w_full_nxt;
            if (w_in_acc) begin
                r_wp <= r_wp + 1'b1;
                if (r_wp == LAST_IDX) begin
                    r_wb <= ~r_wb;
                end
            end
            if (w_out_acc) begin
                r_rp <= r_rp + 1'b1;
                if (r_rp == LAST_IDX) begin
                    r_rb <= ~r_rb;
                end
            end
        end
    end

    assign out_data  = out_valid ? w_rdata[r_rb] : '0;
    assign out_sel   = r_rp[0];
    assign out_first = out_valid && (r_rp == '0);
    assign out_last  = out_valid && (r_rp == LAST_IDX);

endmodule

// File: tb/tb_bitrev_loader.sv
// Directed bench for bitrev_loader with an expected-output queue filled on
// input accepts and drained on output handshakes.
module tb_bitrev_loader;
    localparam int MSB   = 8;
    localparam int LOG2N = 3;
    localparam int N     = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic [MSB-1:0] in_data;
    logic           in_ready;
    logic           out_valid;
    logic           out_ready;
    logic [MSB-1:0] out_data;
    logic           out_sel;
    logic           out_first;
    logic           out_last;

    always #5 clk = ~clk;

    bitrev_loader #(
        .MSB   (MSB),
        .LOG2N (LOG2N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_first (out_first),
        .out_last  (out_last)
    );

    typedef struct packed {
        logic [MSB-1:0] d;
        logic           s;
        logic           f;
        logic           l;
    } exp_t;

    exp_t           q[$];
    logic [MSB-1:0] fb [N];
    int             fcnt;
    int             checks;
    int             errors;
    logic           st_pend;
    logic [MSB-1:0] st_d;
    logic           st_s, st_f, st_l;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] br3(input logic [2:0] i);
        return {i[0], i[1], i[2]};
    endfunction

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle(input logic iv, input logic [MSB-1:0] id, input logic ordy);
        exp_t e;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        if (st_pend) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, st_d);
            chk("hold_sel", out_sel, st_s);
            chk("hold_first", out_first, st_f);
            chk("hold_last", out_last, st_l);
        end
        st_pend = out_valid && !out_ready;
        st_d = out_data; st_s = out_sel; st_f = out_first; st_l = out_last;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("sb_unexpected_out", q.size(), 1);
            end else begin
                e = q.pop_front();
                chk("sb_data", out_data, e.d);
                chk("sb_sel", out_sel, e.s);
                chk("sb_first", out_first, e.f);
                chk("sb_last", out_last, e.l);
            end
        end
        if (in_valid && in_ready) begin
            fb[fcnt] = id;
            if (fcnt == N - 1) begin
                for (int k = 0; k < N; k++) begin
                    e.d = fb[br3(3'(k))];
                    e.s = k[0];
                    e.f = (k == 0);
                    e.l = (k == N - 1);
                    q.push_back(e);
                end
                fcnt = 0;
            end else begin
                fcnt++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int max_cycles, input bit toggle);
        for (int i = 0; i < max_cycles && q.size() > 0; i++) begin
            cycle(1'b0, '0, toggle ? !i[0] : 1'b1);
        end
        chk("drain_done", q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        fcnt = 0;
        st_pend = 1'b0;
        #1;
    endtask

    logic [MSB-1:0] tbl [N];
    int acc;

    initial begin
        checks = 0; errors = 0; fcnt = 0; st_pend = 1'b0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tbl[0] = 8'h10; tbl[1] = 8'h14; tbl[2] = 8'h12; tbl[3] = 8'h16;
        tbl[4] = 8'h11; tbl[5] = 8'h15; tbl[6] = 8'h13; tbl[7] = 8'h17;
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset();

        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sel", out_sel, 0);
        chk("rst_out_first", out_first, 0);
        chk("rst_out_last", out_last, 0);

        // Single frame, fixed expected order.
        for (int i = 0; i < N; i++) begin
            chk("valid_before_full", out_valid, 0);
            cycle(1'b1, 8'(8'h10 + i), 1'b1);
        end
        chk("latency_valid", out_valid, 1);
        chk("latency_data", out_data, 8'h10);
        for (int i = 0; i < N; i++) begin
            chk("seq_data", out_data, tbl[i]);
            cycle(1'b0, '0, 1'b1);
        end
        chk("after_frame_valid", out_valid, 0);

        // Four back-to-back frames.
        for (int i = 0; i < 4 * N; i++) begin
            chk("stream_in_ready", in_ready, 1);
            if (i >= N) chk("stream_gap_free", out_valid, 1);
            cycle(1'b1, 8'(8'h50 + i), 1'b1);
        end
        drain(20, 1'b0);

        // Both banks fill while the output is stalled.
        do_reset();
        for (int i = 0; i < 2 * N; i++) begin
            cycle(1'b1, 8'(8'h10 + i), 1'b0);
        end
        in_valid = 1'b1; in_data = 8'h20; out_ready = 1'b0;
        #1;
        chk("stall_in_ready_low", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_out_data", out_data, 8'h10);
        chk("stall_out_sel", out_sel, 0);
        cycle(1'b1, 8'h20, 1'b0);
        for (int i = 0; i < N; i++) begin
            chk("drain_in_ready_low", in_ready, 0);
            cycle(1'b1, 8'h20, 1'b1);
        end
        chk("in_ready_return", in_ready, 1);

        // Toggling out_ready while the next frame fills and the other drains.
        acc = 0;
        for (int j = 0; j < 40 && acc < N; j++) begin
            if (in_ready) begin
                cycle(1'b1, 8'(8'h20 + acc), j[0]);
                acc++;
            end else begin
                cycle(1'b1, 8'(8'h20 + acc), j[0]);
            end
        end
        chk("toggle_accepts", acc, N);
        drain(60, 1'b1);

        // Reset in the middle of a frame.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 8'(8'h30 + i), 1'b1);
        end
        do_reset();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_data", out_data, 0);
        for (int i = 0; i < N; i++) begin
            cycle(1'b1, 8'(8'h40 + i), 1'b1);
        end
        chk("fresh_first_data", out_data, 8'h40);
        drain(20, 1'b0);
        chk("final_out_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bitrev_loader.md
# bitrev_loader

Input reordering stage for the radix-2 FFT stage. Accepts natural-order samples through a valid/ready handshake into a ping-pong pair of N-sample frame banks, then replays each complete frame in bit-reversed index order. For every output sample it drives the data word and the lane select consumed directly by the downstream `demux` (`sel`, `data_in`), so even-count samples go to lane 0 and odd-count samples to lane 1. One frame can fill while the other drains, which sustains one sample per cycle.

## Interface
- `MSB`, default 8: sample width in bits; must match the `demux` `MSB`.
- `LOG2N`, default 3: log2 of frame length; N = 2^LOG2N points, LOG2N >= 1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream sample valid.
- `in_data` in MSB: upstream sample, natural order.
- `in_ready` out 1: a sample is accepted on an edge where `in_valid && in_ready`.
- `out_valid` out 1: `out_data`/`out_sel` hold a valid sample.
- `out_ready` in 1: downstream accepts on an edge where `out_valid && out_ready`.
- `out_data` out MSB: bit-reversed-order sample; drives `demux.data_in`.
- `out_sel` out 1: lane select; drives `demux.sel`.
- `out_first` out 1: high with the first sample of a frame.
- `out_last` out 1: high with the last sample of a frame.

## Operation
- Storage: 2 banks x N words x MSB bits of registers, no reset of contents.
- State: write bank `wb`, write pointer `wp` (LOG2N bits), read bank `rb`, read pointer `rp` (LOG2N bits), `full[1:0]`.
- Write: `in_ready = !full[wb]`. On accept, mem[wb][wp] <= in_data and wp <= wp+1. If the accept has wp == N-1, then full[wb] <= 1, wb <= ~wb, and wp wraps to 0.
- Read: `out_valid = full[rb]`. `out_data = mem[rb][bitrev(rp)]` while valid, 0 otherwise. `out_sel = rp[0]`. `out_first = out_valid && rp == 0`. `out_last = out_valid && rp == N-1`.
- On an output handshake, rp <= rp+1. If the handshake has rp == N-1, then full[rb] <= 0, rb <= ~rb, and rp wraps to 0.
- Per-bank life cycle: EMPTY -> FILLING (wb points at it, wp > 0) -> FULL -> DRAINING (rb points at it, rp > 0) -> EMPTY.
- Write and read never target the same bank in the same cycle. Set and clear of `full` therefore cannot collide, and both handshakes may occur on the same edge.
- Both banks full: `in_ready` = 0 until the read side completes a frame. `in_ready` rises in the cycle after the last-sample handshake.
- `out_ready` low: `out_data`, `out_sel`, `out_first`, `out_last` and `out_valid` hold stable.
- Reset: wp = rp = 0, wb = rb = 0, full = 00. Reset mid-frame discards any partial or full frames.
- Outputs after reset: in_ready = 1, out_valid = 0, out_data = 0, out_sel = 0, out_first = 0, out_last = 0.

## Timing
- Latency: if sample N-1 of a frame is accepted on edge k, `out_valid` is high in the cycle after edge k and sample bitrev(0) = index 0 is presented then.
- Output path is combinational from registers. There is no output register stage.
- Throughput: 1 sample/cycle sustained on both sides once the first frame is full.
- `in_ready` depends only on registered state, never on `in_valid`. `out_valid` never depends on `out_ready`.

## Structure
- Shared package `fft_pkg`:
  - `LOG2N` / `MSB` default constants.
  - The `bitrev(idx, LOG2N)` function.
  - The bank-index typedef.
  - These are also used by the later FFT stages.
- One natural sub-module, `frame_bank`: an N x MSB register file with a write port and a combinational read port, instantiated twice.

## Test plan
- N=8, feed 0x10..0x17 back-to-back with out_ready=1:
  - out_data sequence is 10,14,12,16,11,15,13,17.
  - out_sel is 0,1,0,1,0,1,0,1.
  - out_first is set on 0x10 and out_last on 0x17.
  - out_valid rises one cycle after 0x17 is accepted.
- Continuous stream of 4 frames with out_ready=1: in_ready is never deasserted after reset, and output is gap-free after the first frame.
- out_ready=0 throughout, feed 17 samples: in_ready drops after the 16th accept, and out_data holds 0x10 with out_sel=0.
- Then pulse out_ready for 8 cycles: frame 0 drains, and in_ready returns the following cycle.
- out_ready toggling 1/0 every cycle during a drain: every accepted sample appears exactly once in bit-reversed order, and outputs hold stable while stalled.
- Assert rst after 5 samples of a frame: the next cycle shows out_valid=0, in_ready=1, out_data=0. A fresh 8-sample frame then reorders correctly with no stale data.
